fifo_reader: RTL and testbench

Drains a single-clock BRAM FIFO through its read port (read-enable / read-valid handshake with one-cycle read latency) and re-presents the words as a valid/ready stream to a downstream pipeline stage. It reads an exact, software-programmed number of words per command, absorbs the FIFO's read latency in a small local buffer so that back-pressure never drops data, and signals completion. It sits between any producer-side FIFO and compute or memory-write engines that need flow-controlled input.

---
 rtl/fifo_reader_if.sv | 33 +++
 rtl/fifo_reader.sv | 123 ++++++++++++
 tb/tb_fifo_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// FIFO read-port and output-stream signals of fifo_reader, bundled for port hookup.
// The master side is the reader; the slave side is the FIFO/downstream environment.
interface fifo_reader_if #(
    parameter int WIDTH = 512
);
    logic             fifo_re;
    logic             fifo_rvalid;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_empty;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output fifo_re,
        input  fifo_rvalid,
        input  fifo_rdata,
        input  fifo_empty,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  fifo_re,
        output fifo_rvalid,
        output fifo_rdata,
        output fifo_empty,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/fifo_reader.sv
// Reads an exact number of words from a one-cycle-latency FIFO read port and
// re-presents them as a valid/ready stream through a 4-entry skid buffer.
module fifo_reader #(
    parameter int WIDTH       = 512,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    output logic                   busy,
    output logic                   done,
    output logic                   protocol_err,
    fifo_reader_if.master          bus
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] target_q, target_d;
    logic [COUNT_WIDTH-1:0] issued_q, issued_d;
    logic [COUNT_WIDTH-1:0] delivered_q, delivered_d;
    logic [2:0]             occ_q, occ_d;
    logic [2:0]             pending_q, pending_d;
    logic [1:0]             wr_ptr_q, wr_ptr_d;
    logic [1:0]             rd_ptr_q, rd_ptr_d;
    logic                   re_last_q, re_last_d;
    logic                   err_q, err_d;
    logic [WIDTH-1:0]       buf_q [4];

    logic       fifo_re;
    logic       push;
    logic       pop;
    logic       timeout;
    logic [3:0] in_flight;

    // Reads are only issued when the buffer is guaranteed room for every outstanding word.
    always_comb begin
        in_flight = {1'b0, occ_q} + {1'b0, pending_q};
        fifo_re   = (state_q == READ) && !bus.fifo_empty && (issued_q < target_q)
                    && (in_flight < 4'd4);
        push      = (state_q == READ) && bus.fifo_rvalid && (pending_q != 3'd0);
        timeout   = (state_q == READ) && re_last_q && !bus.fifo_rvalid;
        pop       = (occ_q != 3'd0) && bus.out_ready;
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        issued_d    = issued_q + COUNT_WIDTH'(fifo_re) - COUNT_WIDTH'(timeout);
        delivered_d = delivered_q + COUNT_WIDTH'(pop);
        pending_d   = pending_q + 3'(fifo_re) - 3'(push) - 3'(timeout);
        occ_d       = occ_q + 3'(push) - 3'(pop);
        wr_ptr_d    = wr_ptr_q + 2'(push);
        rd_ptr_d    = rd_ptr_q + 2'(pop);
        re_last_d   = fifo_re;
        err_d       = err_q | ((state_q == READ) && bus.fifo_rvalid && (pending_q == 3'd0));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = READ;
                    target_d    = num_words;
                    issued_d    = '0;
                    delivered_d = '0;
                    pending_d   = '0;
                    occ_d       = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    re_last_d   = 1'b0;
                end
            end
            READ: begin
                if (delivered_d == target_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            pending_q   <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            re_last_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            pending_q   <= pending_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            re_last_q   <= re_last_d;
            err_q       <= err_d;
        end
    end

    // Data storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= bus.fifo_rdata;
        end
    end

    assign bus.fifo_re   = fifo_re;
    assign bus.out_valid = (occ_q != 3'd0);
    assign bus.out_data  = buf_q[rd_ptr_q];
    assign busy          = (state_q == READ);
    assign done          = (state_q == DONE);
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader: a queue-based FIFO and word-count model predict
// every output each cycle, plus directed cycle-exact checks for the headline scenarios.
module tb_fifo_reader;

    localparam int W  = 64;
    localparam int CW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_words;
    logic          busy;
    logic          done;
    logic          protocol_err;

    fifo_reader_if #(.WIDTH(W)) bus ();

    fifo_reader #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .protocol_err (protocol_err),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] held_q[$];
    int  target, got_cnt, del_cnt;
    bit  active, done_due, err_exp, inflight;
    int  cyc, start_cyc, re_count, done_cyc, first_valid_cyc;
    int  ready_mode, lie_pct, hide_pct, spur_pct;
    logic         nxt_rvalid;
    logic [W-1:0] nxt_rdata;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, observed, expected);
        end
    endtask

    // Drives the FIFO-side and downstream inputs for the coming cycle.
    task automatic applyStimulus();
        bus.fifo_rvalid = nxt_rvalid;
        bus.fifo_rdata  = nxt_rdata;
        if (fifo_q.size() == 0) bus.fifo_empty = ($urandom_range(99) < lie_pct) ? 1'b0 : 1'b1;
        else                    bus.fifo_empty = ($urandom_range(99) < hide_pct) ? 1'b1 : 1'b0;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(1));
            default: bus.out_ready = ((cyc % 4) == 0);
        endcase
    endtask

    // One clock: predict and check mid-cycle, advance the model over the edge, drive next inputs.
    task automatic runCycle();
        bit exp_re, exp_valid, pop, next_done;
        @(negedge clk);
        exp_valid = (held_q.size() != 0);
        exp_re    = active && !bus.fifo_empty && ((got_cnt + int'(inflight)) < target)
                    && ((held_q.size() + int'(inflight)) < 4);
        checkOutput("fifo_re",      W'(bus.fifo_re),   W'(exp_re));
        checkOutput("out_valid",    W'(bus.out_valid), W'(exp_valid));
        if (exp_valid) checkOutput("out_data", bus.out_data, held_q[0]);
        checkOutput("done",         W'(done),          W'(done_due));
        checkOutput("busy",         W'(busy),          W'(active));
        checkOutput("protocol_err", W'(protocol_err),  W'(err_exp));
        if (bus.fifo_re) re_count++;
        if (done) done_cyc = cyc;
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        nxt_rvalid = 1'b0;
        nxt_rdata  = '0;
        if (bus.fifo_re && fifo_q.size() != 0) begin
            nxt_rvalid = 1'b1;
            nxt_rdata  = fifo_q.pop_front();
        end else if (!bus.fifo_re && active && $urandom_range(99) < spur_pct) begin
            nxt_rvalid = 1'b1;
            nxt_rdata  = {$urandom, $urandom};
        end

        next_done = 1'b0;
        if (!reset) begin
            active = 0; done_due = 0; err_exp = 0; inflight = 0;
            held_q.delete(); got_cnt = 0; del_cnt = 0; target = 0;
        end else begin
            if (active) begin
                pop = exp_valid && bus.out_ready;
                if (pop) begin
                    void'(held_q.pop_front());
                    del_cnt++;
                end
                if (bus.fifo_rvalid) begin
                    if (inflight) begin
                        held_q.push_back(bus.fifo_rdata);
                        got_cnt++;
                    end else begin
                        err_exp = 1;
                    end
                end
                if (del_cnt == target) begin
                    next_done = 1'b1;
                    active    = 0;
                end
            end else if (!done_due && start) begin
                active  = 1;
                target  = int'(num_words);
                got_cnt = 0;
                del_cnt = 0;
            end
            done_due = next_done;
            inflight = exp_re;
        end
        @(posedge clk);
        #1;
        cyc++;
        applyStimulus();
    endtask

    task automatic pushWords(input int n, input bit counting);
        for (int i = 0; i < n; i++) fifo_q.push_back(counting ? W'(i) : {$urandom, $urandom});
    endtask

    task automatic startCommand(input int n);
        start           = 1'b1;
        num_words       = CW'(n);
        start_cyc       = cyc;
        first_valid_cyc = -1;
        done_cyc        = -1;
        re_count        = 0;
        runCycle();
        start = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while ((active || done_due) && n < bound) begin
            runCycle();
            n++;
        end
        checkOutput("cmd_finished", W'(!(active || done_due)), W'(1));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_words = '0;
        bus.fifo_rvalid = 1'b0; bus.fifo_rdata = '0; bus.fifo_empty = 1'b1; bus.out_ready = 1'b1;
        nxt_rvalid = 1'b0; nxt_rdata = '0;
        target = 0; got_cnt = 0; del_cnt = 0;
        active = 0; done_due = 0; err_exp = 0; inflight = 0;
        cyc = 0; ready_mode = 0; lie_pct = 0; hide_pct = 0; spur_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) runCycle();

        $display("[TB] basic 8 words");
        pushWords(8, 1'b1);
        startCommand(8);
        waitIdle(100);
        checkOutput("basic_first_valid", W'(first_valid_cyc - start_cyc), W'(3));
        checkOutput("basic_done_cycle",  W'(done_cyc - start_cyc),        W'(11));
        checkOutput("basic_re_count",    W'(re_count),                    W'(8));

        $display("[TB] back-pressure 16 words");
        ready_mode = 2;
        pushWords(16, 1'b0);
        startCommand(16);
        waitIdle(400);
        ready_mode = 0;

        $display("[TB] empty stall");
        fifo_q.delete();
        runCycle();
        startCommand(4);
        repeat (10) runCycle();
        checkOutput("stall_no_reads", W'(re_count), W'(0));
        pushWords(4, 1'b0);
        waitIdle(100);
        checkOutput("stall_re_count", W'(re_count), W'(4));

        $display("[TB] zero length");
        startCommand(0);
        waitIdle(20);
        checkOutput("zero_done_cycle", W'(done_cyc - start_cyc), W'(2));
        checkOutput("zero_re_count",   W'(re_count),             W'(0));

        $display("[TB] reset mid-command");
        ready_mode = 1;
        pushWords(20, 1'b0);
        startCommand(8);
        for (int i = 0; i < 200 && del_cnt < 3; i++) runCycle();
        checkOutput("reset_reached_3", W'(del_cnt), W'(3));
        reset = 1'b0;
        runCycle();
        reset = 1'b1;
        runCycle();
        startCommand(2);
        waitIdle(100);
        ready_mode = 0;

        $display("[TB] protocol error");
        fifo_q.delete();
        runCycle();
        startCommand(3);
        spur_pct = 100;
        repeat (3) runCycle();
        spur_pct = 0;
        pushWords(3, 1'b0);
        waitIdle(100);
        repeat (3) runCycle();
        checkOutput("err_sticky", W'(protocol_err), W'(1));
        reset = 1'b0;
        runCycle();
        reset = 1'b1;
        runCycle();

        $display("[TB] randomized commands");
        ready_mode = 1; lie_pct = 20; hide_pct = 20;
        for (int k = 0; k < 12; k++) begin
            int n;
            n = $urandom_range(20);
            pushWords(n, 1'b0);
            startCommand(n);
            runCycle();
            start = 1'b1;
            num_words = CW'(7);
            runCycle();
            start = 1'b0;
            waitIdle(2000);
            repeat ($urandom_range(3)) runCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
